axis_interpolator_sequencer: RTL and testbench

Segment sequencer placed in front of an axis_interpolator instance. Accepts segment descriptors on a command stream; each descriptor is {sample count, repeat ratio}. For each descriptor it programs the interpolator's cfg_data and passes exactly that many input samples through to the interpolator's slave port. Between segments the data path stays closed, so a new ratio is never applied mid-segment.

---
 rtl/axis_interpolator_sequencer.sv | 114 +++++++++++
 tb/tb_axis_interpolator_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_interpolator_sequencer.sv
// Segment sequencer in front of axis_interpolator: programs cfg_data per descriptor and gates exactly N samples through.
// Optional macro AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN adds cfg_loop to replay the current segment without new commands.
module axis_interpolator_sequencer #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 32,
   parameter int SMPL_WIDTH       = 32,
   parameter int STS_WIDTH        = 32
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [SMPL_WIDTH+CNTR_WIDTH-1:0] s_axis_cmd_tdata,
   input  logic                             s_axis_cmd_tvalid,
   output logic                             s_axis_cmd_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0]      s_axis_tdata,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]      m_axis_tdata,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
   input  logic                             cfg_loop,
`endif
   output logic [CNTR_WIDTH-1:0]            cfg_data,
   output logic [STS_WIDTH-1:0]             sts_data,
   output logic                             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   logic [1:0]            state;
   logic                  enbl_reg;
   logic [CNTR_WIDTH-1:0] ratio_reg;
   logic [CNTR_WIDTH-1:0] cfg_reg;
   logic [SMPL_WIDTH-1:0] remain_reg;
   logic [STS_WIDTH-1:0]  sts_reg;
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
   logic [SMPL_WIDTH-1:0] count_reg;
`endif

   logic [CNTR_WIDTH-1:0] cmd_ratio;
   logic [SMPL_WIDTH-1:0] cmd_count;
   logic                  cmd_fire;
   logic                  data_fire;

   assign cmd_ratio = s_axis_cmd_tdata[CNTR_WIDTH-1:0];
   assign cmd_count = s_axis_cmd_tdata[SMPL_WIDTH+CNTR_WIDTH-1:CNTR_WIDTH];
   assign cmd_fire  = (state == IDLE) && enbl_reg && s_axis_cmd_tvalid;
   assign data_fire = (state == RUN) && s_axis_tvalid && m_axis_tready;

   // cfg_data is only written in LOAD, so the interpolator never sees a ratio change mid-segment
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state      <= IDLE;
         enbl_reg   <= 1'b0;
         ratio_reg  <= '0;
         cfg_reg    <= '0;
         remain_reg <= '0;
         sts_reg    <= '0;
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
         count_reg  <= '0;
`endif
      end else begin
         enbl_reg <= 1'b1;
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  ratio_reg  <= cmd_ratio;
                  remain_reg <= cmd_count;
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
                  count_reg  <= cmd_count;
`endif
                  if (cmd_count != '0) begin
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               cfg_reg <= ratio_reg;
               state   <= RUN;
            end
            RUN: begin
               if (data_fire) begin
                  remain_reg <= remain_reg - SMPL_WIDTH'(1);
                  if (remain_reg == SMPL_WIDTH'(1)) begin
                     sts_reg <= sts_reg + STS_WIDTH'(1);
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
                     // Looping keeps the ratio, so LOAD is skipped and the count is replayed
                     if (cfg_loop) begin
                        remain_reg <= count_reg;
                     end else begin
                        state <= IDLE;
                     end
`else
                     state <= IDLE;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign s_axis_cmd_tready = (state == IDLE) && enbl_reg;
   assign s_axis_tready     = (state == RUN) && m_axis_tready;
   assign m_axis_tvalid     = (state == RUN) && s_axis_tvalid;
   assign m_axis_tdata      = s_axis_tdata;
   assign cfg_data          = cfg_reg;
   assign sts_data          = sts_reg;
   assign busy              = (state != IDLE);

endmodule

// File: tb/tb_axis_interpolator_sequencer.sv
// Self-checking bench for axis_interpolator_sequencer: transaction-level model plus a simple interpolator stand-in.
// Loop scenario is compiled only with AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN defined.
module tb_axis_interpolator_sequencer;

   localparam int DW = 32;
   localparam int CW = 32;
   localparam int SW = 32;
   localparam int TW = 32;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic [SW+CW-1:0] s_axis_cmd_tdata;
   logic          s_axis_cmd_tvalid;
   logic          s_axis_cmd_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [CW-1:0] cfg_data;
   logic [TW-1:0] sts_data;
   logic          busy;
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
   logic          cfg_loop;
`endif

   always #5 aclk = ~aclk;

   axis_interpolator_sequencer #(
      .AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW), .SMPL_WIDTH(SW), .STS_WIDTH(TW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_cmd_tdata(s_axis_cmd_tdata), .s_axis_cmd_tvalid(s_axis_cmd_tvalid),
      .s_axis_cmd_tready(s_axis_cmd_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
      .cfg_loop(cfg_loop),
`endif
      .cfg_data(cfg_data), .sts_data(sts_data), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: segment bookkeeping in plain integers
   bit          mEnbl  = 1'b0;
   int          mRemain = 0;
   int          mWait  = 0;
   int          mCount = 0;
   logic [31:0] mRatio = '0;
   logic [31:0] mCfg   = '0;
   logic [31:0] mSts   = '0;
   bit          chkEn  = 1'b0;

   // Interpolator stand-in and source bookkeeping
   int          irep = 0;
   logic [31:0] lastBeat = '0;
   int          srcIdx = 0;
   int          hsCount = 0;
   bit          srcRand = 1'b0;
   bit          dsRand = 1'b0;

   logic [31:0] expData[$];
   logic [31:0] expRep[$];
   logic [31:0] beats[$];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, then advance model and interpolator for the coming edge
   always @(negedge aclk) begin
      bit idle;
      bit open;
      bit cfire;
      bit mfire;
      idle = (mRemain == 0);
      open = !idle && (mWait == 0);
      if (chkEn) begin
         checkOutput("cmd_tready", s_axis_cmd_tready, idle && mEnbl);
         checkOutput("busy", busy, !idle);
         checkOutput("s_tready", s_axis_tready, open && m_axis_tready);
         checkOutput("m_tvalid", m_axis_tvalid, open && s_axis_tvalid);
         if (open && s_axis_tvalid) checkOutput("m_tdata", m_axis_tdata, s_axis_tdata);
         checkOutput("cfg_data", cfg_data, mCfg);
         checkOutput("sts_data", sts_data, mSts);
      end
      if (!aresetn) begin
         irep = 0;
      end else if (m_axis_tvalid && m_axis_tready) begin
         beats.push_back(m_axis_tdata);
         lastBeat = m_axis_tdata;
         irep = int'(cfg_data);
      end else if (irep > 0) begin
         beats.push_back(lastBeat);
         irep--;
      end
      if (aresetn && s_axis_tvalid && s_axis_tready) begin
         srcIdx++;
         hsCount++;
      end
      if (!aresetn) begin
         mEnbl = 1'b0; mRemain = 0; mWait = 0; mCfg = '0; mSts = '0;
         chkEn = 1'b1;
      end else begin
         cfire = idle && mEnbl && s_axis_cmd_tvalid;
         mfire = open && s_axis_tvalid && m_axis_tready;
         if (cfire) begin
            if (s_axis_cmd_tdata[SW+CW-1:CW] != '0) begin
               mRemain = int'(s_axis_cmd_tdata[SW+CW-1:CW]);
               mCount  = mRemain;
               mRatio  = s_axis_cmd_tdata[CW-1:0];
               mWait   = 1;
            end
         end else if (!idle && mWait > 0) begin
            mWait = 0;
            mCfg  = mRatio;
         end else if (mfire) begin
            expData.push_back(s_axis_tdata);
            expRep.push_back(mCfg);
            mRemain--;
            if (mRemain == 0) begin
               mSts++;
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
               if (cfg_loop) mRemain = mCount;
`endif
            end
         end
         mEnbl = 1'b1;
      end
   end

   task automatic applyStimulus(input int count, input int ratio);
      bit got;
      got = 1'b0;
      s_axis_cmd_tdata  = {SW'(count), CW'(ratio)};
      s_axis_cmd_tvalid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge aclk); #1;
         if (s_axis_cmd_tready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge aclk); #1;
      s_axis_cmd_tvalid = 1'b0;
      if (!got) checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic waitIdle(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge aclk); #1;
         if (!busy && irep == 0 && !s_axis_cmd_tvalid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) checkOutput("idle_timeout", 64'd0, 64'd1);
   endtask

   // Expands each accepted sample by (ratio+1) and compares with the interpolator's beat stream
   task automatic checkBeats(input string name);
      logic [31:0] want[$];
      int n;
      foreach (expData[i]) begin
         for (int r = 0; r <= int'(expRep[i]); r++) want.push_back(expData[i]);
      end
      checkOutput({name, "_beat_count"}, beats.size(), want.size());
      n = (beats.size() < want.size()) ? beats.size() : want.size();
      for (int i = 0; i < n; i++) checkOutput({name, "_beat"}, beats[i], want[i]);
      expData.delete();
      expRep.delete();
      beats.delete();
   endtask

   task automatic doReset();
      @(posedge aclk); #1;
      aresetn = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int h0;
      bit seen;
      aresetn = 1'b0;
      s_axis_cmd_tdata = '0;
      s_axis_cmd_tvalid = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      m_axis_tready = 1'b0;
`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
      cfg_loop = 1'b0;
`endif
      fork
         forever begin
            @(posedge aclk); #1;
            s_axis_tvalid = srcRand ? ($urandom_range(0, 1) == 1) : 1'b1;
            m_axis_tready = (irep == 0) && (dsRand ? ($urandom_range(0, 2) != 0) : 1'b1);
            s_axis_tdata  = 32'hA000_0000 + 32'(srcIdx);
         end
      join_none

      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      @(negedge aclk); #1;
      checkOutput("rst_cfg", cfg_data, 64'd0);
      checkOutput("rst_sts", sts_data, 64'd0);
      checkOutput("rst_busy", busy, 64'd0);
      checkOutput("rst_mvalid", m_axis_tvalid, 64'd0);

      $display("[TB] scenario 1: count=4 ratio=2");
      base = srcIdx;
      applyStimulus(4, 2);
      waitIdle(200);
      checkOutput("t1_sts", sts_data, 64'd1);
      checkOutput("t1_cfg", cfg_data, 64'd2);
      checkOutput("t1_beats", beats.size(), 64'd12);
      for (int i = 0; i < 12 && i < beats.size(); i++)
         checkOutput("t1_seq", beats[i], 32'hA000_0000 + 32'(base + i / 3));
      checkBeats("t1");

      $display("[TB] scenario 2: count=0 then count=1 ratio=0");
      doReset();
      base = srcIdx;
      applyStimulus(0, 7);
      applyStimulus(1, 0);
      waitIdle(200);
      checkOutput("t2_sts", sts_data, 64'd1);
      checkOutput("t2_beats", beats.size(), 64'd1);
      if (beats.size() > 0) checkOutput("t2_data", beats[0], 32'hA000_0000 + 32'(base));
      checkBeats("t2");

      $display("[TB] scenario 3: back-to-back {2,3} {2,1}");
      doReset();
      base = srcIdx;
      applyStimulus(2, 3);
      applyStimulus(2, 1);
      waitIdle(200);
      checkOutput("t3_sts", sts_data, 64'd2);
      checkOutput("t3_cfg", cfg_data, 64'd1);
      checkOutput("t3_beats", beats.size(), 64'd12);
      for (int i = 0; i < 12 && i < beats.size(); i++)
         checkOutput("t3_seq", beats[i],
                     32'hA000_0000 + 32'(base + ((i < 8) ? (i / 4) : (2 + (i - 8) / 2))));
      checkBeats("t3");

      $display("[TB] scenario 4: random handshakes, count=100 ratio=5");
      doReset();
      srcRand = 1'b1;
      dsRand  = 1'b1;
      h0 = hsCount;
      applyStimulus(100, 5);
      waitIdle(5000);
      srcRand = 1'b0;
      dsRand  = 1'b0;
      checkOutput("t4_handshakes", hsCount - h0, 64'd100);
      checkOutput("t4_beats", beats.size(), 64'd600);
      checkOutput("t4_sts", sts_data, 64'd1);
      checkBeats("t4");

      $display("[TB] scenario 5: reset mid-segment");
      doReset();
      h0 = hsCount;
      applyStimulus(10, 0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge aclk); #1;
         if (hsCount - h0 >= 2) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput("t5_progress_timeout", 64'd0, 64'd1);
      @(posedge aclk); #1;
      aresetn = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk); #1;
      checkOutput("t5_sts", sts_data, 64'd0);
      checkOutput("t5_busy", busy, 64'd0);
      checkOutput("t5_cfg", cfg_data, 64'd0);
      checkOutput("t5_mvalid", m_axis_tvalid, 64'd0);
      checkOutput("t5_stready", s_axis_tready, 64'd0);
      checkBeats("t5a");
      applyStimulus(2, 4);
      waitIdle(200);
      checkOutput("t5_sts_after", sts_data, 64'd1);
      checkOutput("t5_beats_after", beats.size(), 64'd10);
      checkBeats("t5b");

`ifdef AXIS_INTERPOLATOR_SEQUENCER_LOOP_EN
      $display("[TB] scenario 6: loop count=3 ratio=1");
      doReset();
      cfg_loop = 1'b1;
      applyStimulus(3, 1);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge aclk); #1;
         if (sts_data == 3) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput("t6_loop_timeout", 64'd0, 64'd1);
      checkOutput("t6_cmd_tready", s_axis_cmd_tready, 64'd0);
      @(posedge aclk); #1;
      cfg_loop = 1'b0;
      waitIdle(200);
      checkOutput("t6_sts", sts_data, 64'd4);
      checkOutput("t6_beats", beats.size(), 64'd24);
      checkBeats("t6");
`endif

      repeat (3) @(posedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
